// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_parity_calc.sv
// Combinational parity generator: even parity is the XOR of the word, odd its complement.
module parity_calc
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a first-word-fall-through FIFO and sends each one as a UART frame,
// one bit per CLK: start, data LSB first, optional parity, stop.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  R_INC,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    pop;
  logic                    par_bit_in;

  // A word can only be taken when the line is idle or finishing its stop bit.
  assign pop   = !RST && !EMPTY && (state_q == IDLE || state_q == STOP);
  assign R_INC = pop;

  // Parity is taken from the word at pop time, so it stays valid while the
  // shift register empties out.
  parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (RD_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_bit_in)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pop) state_d = START;
      START:   state_d = DATA;
      DATA:    if (cnt_q == CNT_LAST) state_d = par_en_q ? PARITY : STOP;
      PARITY:  state_d = STOP;
      STOP:    state_d = pop ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    if (pop) begin
      shift_d   = RD_DATA;
      par_en_d  = PAR_EN;
      par_bit_d = par_bit_in;
    end else if (state_q == DATA) begin
      shift_d = shift_q >> 1;
      cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Line level is registered from the state being entered, so TX_OUT lines up with state_q.
  always_comb begin
    tx_d   = LINE_IDLE;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: a queue-based FIFO and a frame-level line model predict
// R_INC, TX_OUT and BUSY every cycle.
module tb_fifo_uart_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EMPTY;
  logic [7:0] RD_DATA;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       R_INC;
  logic       TX_OUT;
  logic       BUSY;

  fifo_uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EMPTY   (EMPTY),
    .RD_DATA (RD_DATA),
    .PAR_EN  (PAR_EN),
    .PAR_TYP (PAR_TYP),
    .R_INC   (R_INC),
    .TX_OUT  (TX_OUT),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  logic [7:0] fifo_q[$];
  bit         frame_q[$];
  logic       cur_line;
  logic       cur_busy;
  int         n_checks = 0;
  int         n_fails  = 0;
  int         cyc      = 0;
  logic [63:0] cap;
  int         cap_n;
  int         busy_cnt;
  int         pop_cyc[$];

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Line bits of one frame, index 0 is the first bit on the wire.
  function automatic logic [15:0] frame_bits(input logic [7:0] w, input logic pe, input logic pt);
    logic [15:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = w[i];
    if (pe) b[9] = (($countones(w) % 2) == 1) ^ pt;
    return b;
  endfunction

  task automatic drive_fifo();
    EMPTY   = (fifo_q.size() == 0);
    RD_DATA = EMPTY ? 8'($urandom) : fifo_q[0];
  endtask

  task automatic clear_obs();
    cap      = '0;
    cap_n    = 0;
    busy_cnt = 0;
    pop_cyc.delete();
  endtask

  // One clock: compare at the falling edge, advance the model past the rising edge.
  task automatic step();
    logic        exp_pop;
    logic [15:0] fb;
    int          fl;
    fb = '0;
    fl = 0;
    @(negedge CLK);
    exp_pop = !RST && (fifo_q.size() != 0) && (frame_q.size() == 0);
    check_val("tx_out", 64'(TX_OUT), 64'(cur_line));
    check_val("busy",   64'(BUSY),   64'(cur_busy));
    check_val("r_inc",  64'(R_INC),  64'(exp_pop));
    if (BUSY === 1'b1) begin
      busy_cnt++;
      if (cap_n < 64) cap[cap_n] = TX_OUT;
      cap_n++;
    end
    if (R_INC === 1'b1) pop_cyc.push_back(cyc);
    if (exp_pop) begin
      fb = frame_bits(fifo_q[0], PAR_EN, PAR_TYP);
      fl = PAR_EN ? 11 : 10;
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (RST) begin
      frame_q.delete();
      cur_line = 1'b1;
      cur_busy = 1'b0;
    end else begin
      if (exp_pop) begin
        void'(fifo_q.pop_front());
        for (int i = 0; i < fl; i++) frame_q.push_back(fb[i]);
      end
      if (frame_q.size() != 0) begin
        cur_line = frame_q.pop_front();
        cur_busy = 1'b1;
      end else begin
        cur_line = 1'b1;
        cur_busy = 1'b0;
      end
    end
    drive_fifo();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((fifo_q.size() != 0 || frame_q.size() != 0 || cur_busy) && k < 500) begin
      step();
      k++;
    end
    check_val("drain_bound", 64'(k < 500), 64'd1);
    repeat (2) step();
  endtask

  task automatic async_reset(input int hold);
    RST = 1'b1;
    #1;
    check_val("rst_async_tx",   64'(TX_OUT), 64'd1);
    check_val("rst_async_busy", 64'(BUSY),   64'd0);
    check_val("rst_async_rinc", 64'(R_INC),  64'd0);
    frame_q.delete();
    cur_line = 1'b1;
    cur_busy = 1'b0;
    repeat (hold) step();
    RST = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] fb;
    int          rel;
    int          k;
    RST      = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    cur_line = 1'b1;
    cur_busy = 1'b0;
    clear_obs();
    drive_fifo();
    #1;
    check_val("reset_tx",   64'(TX_OUT), 64'd1);
    check_val("reset_busy", 64'(BUSY),   64'd0);
    check_val("reset_rinc", 64'(R_INC),  64'd0);

    // Model pins against hand-derived frames.
    fb = frame_bits(8'hA5, 1'b0, 1'b0);
    check_val("model_a5_noparity", 64'(fb[9:0]), 64'(10'b1101001010));
    fb = frame_bits(8'hA5, 1'b1, 1'b0);
    check_val("model_a5_even", 64'(fb[9]), 64'd0);
    fb = frame_bits(8'hA5, 1'b1, 1'b1);
    check_val("model_a5_odd", 64'(fb[9]), 64'd1);

    repeat (3) step();
    RST = 1'b0;
    repeat (2) step();

    // Single 0xA5 frame, parity off.
    clear_obs();
    fifo_q.push_back(8'hA5);
    drive_fifo();
    drain();
    check_val("a5_pops",  64'(pop_cyc.size()), 64'd1);
    check_val("a5_busy",  64'(busy_cnt), 64'd10);
    check_val("a5_line",  64'(cap[9:0]), 64'(10'b1101001010));

    // 0xA5 with even then odd parity.
    for (int pt = 0; pt < 2; pt++) begin
      clear_obs();
      PAR_EN  = 1'b1;
      PAR_TYP = pt[0];
      fifo_q.push_back(8'hA5);
      drive_fifo();
      drain();
      check_val("a5p_busy", 64'(busy_cnt), 64'd11);
      check_val("a5p_line", 64'(cap[10:0]), 64'({1'b1, pt[0], 8'hA5, 1'b0}));
    end

    // Three back-to-back frames.
    clear_obs();
    PAR_EN = 1'b0;
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h80);
    fifo_q.push_back(8'hFF);
    drive_fifo();
    drain();
    check_val("b2b_pops", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() == 3) begin
      check_val("b2b_gap0", 64'(pop_cyc[1] - pop_cyc[0]), 64'd10);
      check_val("b2b_gap1", 64'(pop_cyc[2] - pop_cyc[1]), 64'd10);
    end
    check_val("b2b_busy", 64'(busy_cnt), 64'd30);
    check_val("b2b_line", 64'(cap[29:0]),
              64'({1'b1, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 8'h01, 1'b0}));

    // Empty FIFO for 50 cycles.
    clear_obs();
    repeat (50) step();
    check_val("empty_pops", 64'(pop_cyc.size()), 64'd0);
    check_val("empty_busy", 64'(busy_cnt), 64'd0);

    // Reset during the 4th data bit of 0x3C, then 0x55 after release.
    clear_obs();
    fifo_q.push_back(8'h3C);
    drive_fifo();
    k = 0;
    while (pop_cyc.size() == 0 && k < 20) begin
      step();
      k++;
    end
    check_val("rst_pop_seen", 64'(pop_cyc.size()), 64'd1);
    repeat (4) step();
    check_val("rst_bit3", 64'(TX_OUT), 64'd1);
    fifo_q.push_back(8'h55);
    drive_fifo();
    async_reset(2);
    clear_obs();
    rel = cyc;
    drain();
    check_val("rst_release_pops", 64'(pop_cyc.size()), 64'd1);
    if (pop_cyc.size() != 0)
      check_val("rst_release_first", 64'(pop_cyc[0]), 64'(rel));
    check_val("rst_release_line", 64'(cap[9:0]), 64'({1'b1, 8'h55, 1'b0}));

    // PAR_EN raised mid-frame: applies only from the next pop.
    clear_obs();
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b1;
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'hC3);
    drive_fifo();
    repeat (4) step();
    PAR_EN = 1'b1;
    drain();
    check_val("paren_pops", 64'(pop_cyc.size()), 64'd2);
    if (pop_cyc.size() == 2)
      check_val("paren_gap", 64'(pop_cyc[1] - pop_cyc[0]), 64'd10);
    check_val("paren_busy", 64'(busy_cnt), 64'd21);
    check_val("paren_line", 64'(cap[20:0]),
              64'({1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h5A, 1'b0}));

    // Randomised traffic with occasional mid-frame resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8) fifo_q.push_back(8'($urandom));
      if ($urandom_range(0, 7) == 0) PAR_EN  = 1'($urandom);
      if ($urandom_range(0, 7) == 0) PAR_TYP = 1'($urandom);
      drive_fifo();
      if ($urandom_range(0, 299) == 0) async_reset($urandom_range(1, 3));
      else step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer of the asynchronous FIFO: pops one word whenever the FIFO is non-empty and transmits it as a UART frame on a single serial line. The frame is a start bit, DATA_WIDTH data bits LSB first, an optional parity bit and one stop bit. The block runs entirely in the FIFO read clock domain, and its `CLK` is the bit clock (one bit per cycle). It drives the FIFO's `R_INC` and consumes `RD_DATA`/`EMPTY` directly, with no extra synchronisation.

## Interface
- `DATA_WIDTH`, 8, width of each FIFO word and of the frame's data field.
- `CLK`  in  1  bit clock, same as the FIFO read clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `EMPTY`  in  1  FIFO empty flag, read domain.
- `RD_DATA`  in  DATA_WIDTH  FIFO head word; valid whenever `EMPTY`=0 (first-word-fall-through).
- `PAR_EN`  in  1  1 = insert parity bit.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `R_INC`  out  1  pop strobe to the FIFO, combinational, one cycle per word.
- `TX_OUT`  out  1  serial line, registered; idles high.
- `BUSY`  out  1  registered; high while a frame is on the line.

## Operation
- FSM states and transitions:
  - IDLE → START when `EMPTY`=0.
  - START → DATA.
  - DATA → PARITY or STOP. DATA lasts DATA_WIDTH cycles, counted by a bit counter 0..DATA_WIDTH-1. The exit is to PARITY if the latched PAR_EN=1, otherwise to STOP.
  - PARITY → STOP.
  - STOP → START if `EMPTY`=0, otherwise → IDLE.
- Pop rule: `R_INC = !RST && !EMPTY && (state==IDLE || state==STOP)`.
  - On the same edge, `RD_DATA` is loaded into the shift register and `PAR_EN`/`PAR_TYP` are latched.
  - Latched values hold for the whole frame; changes mid-frame have no effect until the next pop.
- Data bits are shifted out LSB first.
- Parity bit: even = XOR of the latched data; odd = XNOR of the latched data.
- `TX_OUT` per state:
  - START: 0.
  - DATA: current shift-register bit 0.
  - PARITY: the parity bit.
  - STOP and IDLE: 1.
- `BUSY` is 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Bit counter width is clog2(DATA_WIDTH). The counter wraps to 0 on the DATA exit.

## Timing
- Reset values: state IDLE, `TX_OUT`=1, `BUSY`=0, `R_INC`=0, shift register 0, counter 0.
- Latency: from the first cycle with `EMPTY`=0 in IDLE, `R_INC` is high in that same cycle. The start bit appears on `TX_OUT` after the next rising edge.
- Frame length is 10 cycles with parity off and 11 with parity on (DATA_WIDTH=8).
- Back-to-back frames: a pop during the STOP cycle gives zero idle gap. Frame period is exactly 10 or 11 cycles.
- Each pop is exactly one `R_INC` cycle. `R_INC` is never asserted while `EMPTY`=1, in START/DATA/PARITY, or during `RST`.
- `EMPTY` rising mid-frame: no effect. The current frame completes, then the block goes to IDLE.
- `RST` asserted mid-frame: immediately IDLE with `TX_OUT`=1. The in-flight word is dropped, not re-read; the FIFO is not notified.
- `RST` deassertion with `EMPTY`=0: the first pop occurs in the first cycle after release.

## Structure
- Shared package `fifo_uart_tx_pkg` contains:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - parity constants PAR_EVEN=0 and PAR_ODD=1;
  - the idle line level constant (1).
- One sub-module: `parity_calc`. It is combinational and parameterised by DATA_WIDTH, with inputs data and type and output parity bit.
- Everything else is in one FSM-plus-datapath module of roughly 150–250 lines.

## Test plan
- Reset, then FIFO loaded with 0xA5, PAR_EN=0:
  - `R_INC` is one pulse.
  - `TX_OUT` sequence is 0,1,0,1,0,0,1,0,1,1.
  - `BUSY` is high for 10 cycles, then `TX_OUT`=1 and `BUSY`=0.
- 0xA5 with PAR_EN=1:
  - PAR_TYP=0 gives parity bit 0; PAR_TYP=1 gives parity bit 1.
  - Frame length is 11 cycles in both cases.
- FIFO holding 0x01, 0x80, 0xFF, parity off:
  - Three frames with no idle gap.
  - `R_INC` pulses exactly 10 cycles apart.
  - Data bits are 1,0,0,0,0,0,0,0 / 0,0,0,0,0,0,0,1 / all 1.
- `EMPTY` held 1 for 50 cycles: `R_INC`=0, `TX_OUT`=1 and `BUSY`=0 throughout.
- `RST` pulsed during the 4th data bit of 0x3C:
  - `TX_OUT` goes to 1 and `BUSY` goes to 0 asynchronously.
  - After release with the FIFO holding 0x55, the next frame carries 0x55 cleanly.
- PAR_EN toggled 0→1 mid-frame: the current frame has no parity bit; the next frame has one.
